// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register pending scoreboard and a hardwired zero register.
// Define REGFILE_BYPASS_EN to forward the WB write (data and pending state) to the read ports in the same cycle.

module regfile_sb_mux #(
    parameter int W  = 64,
    parameter int N  = 32,
    parameter int AW = 5
) (
    input  logic [N-1:0][W-1:0] in_i,
    input  logic [AW-1:0]       sel_i,
    output logic [W-1:0]        out_o
);
    // Stage s halves the candidate set using select bit s; the last stage holds one entry.
    genvar s, j;
    for (s = 0; s < AW; s++) begin : g_stg
        logic [(N>>(s+1))-1:0][W-1:0] n;
        for (j = 0; j < (N >> (s+1)); j++) begin : g_node
            if (s == 0) begin : g_leaf
                assign n[j] = sel_i[s] ? in_i[2*j+1] : in_i[2*j];
            end else begin : g_inner
                assign n[j] = sel_i[s] ? g_stg[s-1].n[2*j+1] : g_stg[s-1].n[2*j];
            end
        end
    end
    assign out_o = g_stg[AW-1].n[0];
endmodule

module regfile_sb #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = DEPTH - 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    output logic             pend_a,
    output logic             pend_b,
    output logic             pend_any
);
    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]            pend_q, pend_d;

    logic             wr_ok, iss_ok;
    logic [WIDTH-1:0] mux_data_a, mux_data_b;
    logic             mux_pend_a, mux_pend_b;

    assign wr_ok  = wr_en && (wr_addr != ZR);
    assign iss_ok = issue_en && (issue_addr != ZR);

    // Issue is applied after the write so a new producer keeps the bit set.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
            pend_d[wr_addr] = 1'b0;
        end
        if (iss_ok) begin
            pend_d[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regs_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    regfile_sb_mux #(.W(WIDTH), .N(DEPTH), .AW(AW)) u_mux_da (
        .in_i(regs_q), .sel_i(rd_addr_a), .out_o(mux_data_a));
    regfile_sb_mux #(.W(WIDTH), .N(DEPTH), .AW(AW)) u_mux_db (
        .in_i(regs_q), .sel_i(rd_addr_b), .out_o(mux_data_b));
    regfile_sb_mux #(.W(1), .N(DEPTH), .AW(AW)) u_mux_pa (
        .in_i(pend_q), .sel_i(rd_addr_a), .out_o(mux_pend_a));
    regfile_sb_mux #(.W(1), .N(DEPTH), .AW(AW)) u_mux_pb (
        .in_i(pend_q), .sel_i(rd_addr_b), .out_o(mux_pend_b));

    assign pend_any = |pend_q;

`ifdef REGFILE_BYPASS_EN
    // WB-to-ID forwarding: the retiring write is visible before the edge.
    always_comb begin
        rd_data_a = mux_data_a;
        pend_a    = mux_pend_a;
        if (reset_n && wr_ok && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
            pend_a    = issue_en && (issue_addr == rd_addr_a);
        end
    end

    always_comb begin
        rd_data_b = mux_data_b;
        pend_b    = mux_pend_b;
        if (reset_n && wr_ok && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
            pend_b    = issue_en && (issue_addr == rd_addr_b);
        end
    end
`else
    assign rd_data_a = mux_data_a;
    assign rd_data_b = mux_data_b;
    assign pend_a    = mux_pend_a;
    assign pend_b    = mux_pend_b;
`endif

endmodule
